// File: rtl/fpsu_issue_sched.sv
// In-order issue scheduler for three FPU ports (u1, u3, u5).
// Requests queue in a DEPTH-entry FIFO; the head op is sent to the first
// available port it allows, round-robin after the last-granted port.
// Each port tracks its in-flight ops with a counter and a tag FIFO so that
// completions return the requester tag in issue order.
module fpsu_issue_sched #(
  parameter int DEPTH  = 4,
  parameter int MAXOUT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  input  logic [12:0] req_op,
  input  logic [8:0]  req_tag,
  input  logic [2:0]  req_pmask,
  output logic        req_rdy,
  input  logic        flush,
  output logic [2:0]  iss_en,
  output logic [12:0] iss_op,
  input  logic [2:0]  ret_en,
  output logic [2:0]  cmpl_vld,
  output logic [8:0]  cmpl_tag0,
  output logic [8:0]  cmpl_tag1,
  output logic [8:0]  cmpl_tag2
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAXOUT + 1);
  localparam int PW = (MAXOUT > 1) ? $clog2(MAXOUT) : 1;

  typedef struct packed {
    logic [12:0] op;
    logic [8:0]  tag;
    logic [2:0]  pmask;
  } entry_t;

  // Issue queue storage and control
  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // Per-port in-flight tracking
  logic [OW-1:0]   out_cnt_q [3];
  logic [OW-1:0]   out_cnt_d [3];
  logic [8:0]      tag_mem_q [3][MAXOUT];
  logic [8:0]      tag_mem_d [3][MAXOUT];
  logic [PW-1:0]   tag_wr_q [3];
  logic [PW-1:0]   tag_wr_d [3];
  logic [PW-1:0]   tag_rd_q [3];
  logic [PW-1:0]   tag_rd_d [3];

  // Arbitration and registered issue outputs
  logic [1:0]      last_q, last_d;
  logic [2:0]      iss_en_q, iss_en_d;
  logic [12:0]     iss_op_q, iss_op_d;

  entry_t          head;
  logic            push, push_keep, sel_vld, ins, rem;
  logic [1:0]      sel_port, idx;
  logic [2:0]      avail, busy, elig, ret_ok;
  logic            err_spur;

  // Tag FIFO pointers wrap at MAXOUT, which need not be a power of two.
  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(MAXOUT - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake, head selection, completion and all next-state values.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    req_rdy   = rst && (count_q < CW'(DEPTH)) && !flush;
    push      = req_vld && req_rdy;
    push_keep = push && (req_pmask != 3'b000);
    head      = mem_q[rd_ptr_q];

    for (int p = 0; p < 3; p++) begin
      avail[p] = out_cnt_q[p] < OW'(MAXOUT);
      busy[p]  = out_cnt_q[p] != '0;
    end

    elig = (count_q != '0 && !flush) ? (head.pmask & avail) : 3'b000;

    // Round-robin: scan the ports starting just after the last grant.
    sel_vld  = 1'b0;
    sel_port = 2'd0;
    idx      = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      idx = 2'((int'(last_q) + k) % 3);
      if (!sel_vld && elig[idx]) begin
        sel_vld  = 1'b1;
        sel_port = idx;
      end
    end

    ret_ok    = ret_en & busy & {3{rst}};
    err_spur  = rst && ((ret_en & ~busy) != 3'b000);
    cmpl_vld  = ret_ok;
    cmpl_tag0 = tag_mem_q[0][tag_rd_q[0]];
    cmpl_tag1 = tag_mem_q[1][tag_rd_q[1]];
    cmpl_tag2 = tag_mem_q[2][tag_rd_q[2]];

    wr_ptr_d = push_keep ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = flush ? wr_ptr_q : (sel_vld ? rd_ptr_q + AW'(1) : rd_ptr_q);
    count_d  = flush ? '0 : count_q + CW'(push_keep) - CW'(sel_vld);

    tag_mem_d = tag_mem_q;
    ins = 1'b0;
    rem = 1'b0;
    for (int p = 0; p < 3; p++) begin
      ins = sel_vld && (sel_port == 2'(p));
      rem = ret_ok[p];
      out_cnt_d[p] = out_cnt_q[p] + OW'(ins) - OW'(rem);
      tag_wr_d[p]  = ins ? inc_ptr(tag_wr_q[p]) : tag_wr_q[p];
      tag_rd_d[p]  = rem ? inc_ptr(tag_rd_q[p]) : tag_rd_q[p];
      if (ins) tag_mem_d[p][tag_wr_q[p]] = head.tag;
    end

    last_d   = sel_vld ? sel_port : last_q;
    iss_en_d = sel_vld ? (3'b001 << sel_port) : 3'b000;
    iss_op_d = sel_vld ? head.op : iss_op_q;
  end

  // Control state, tag FIFOs and issue outputs with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_cnt_q <= '{default: '0};
      tag_wr_q  <= '{default: '0};
      tag_rd_q  <= '{default: '0};
      tag_mem_q <= '{default: '0};
      last_q    <= 2'd2;
      iss_en_q  <= 3'b000;
      iss_op_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      out_cnt_q <= out_cnt_d;
      tag_wr_q  <= tag_wr_d;
      tag_rd_q  <= tag_rd_d;
      tag_mem_q <= tag_mem_d;
      last_q    <= last_d;
      iss_en_q  <= iss_en_d;
      iss_op_q  <= iss_op_d;
    end
  end

  // Queue payload write; a dropped (pmask==0) request never occupies a slot.
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; count and pointers decide validity.
    if (push_keep) mem_q[wr_ptr_q] <= '{op: req_op, tag: req_tag, pmask: req_pmask};
  end

  assign iss_en = iss_en_q;
  assign iss_op = iss_op_q;

  // Invariants: one issue per cycle, and a spurious return never completes.
  a_iss_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(iss_en_q));
  a_spur_quiet : assert property (@(posedge clk) disable iff (!rst)
                                  err_spur |-> ((cmpl_vld & ret_en) != ret_en));

endmodule
